vpifo_pop_scheduler: RTL and testbench

- Weighted round-robin pop scheduler in front of the shared multi-tree SRAM vPIFO task generator.
- Tracks per-tree occupancy of the TREE_NUM logical PIFOs and gates upstream pushes against per-tree capacity and the task-FIFO full flag.
- Issues spaced pop requests, with tree id, to the shared PIFO. Trees are served in round-robin order, with a programmable per-tree weight giving the consecutive-pop quota.

---
 rtl/vpifo_pop_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_vpifo_pop_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpifo_pop_scheduler.sv
// ---------------------------------------------------------------------------
// vpifo_pop_scheduler
// Weighted round-robin pop scheduler in front of a shared multi-tree vPIFO.
// Tracks per-tree occupancy, gates upstream pushes against tree capacity and
// the task-FIFO full flag, and issues spaced pop strobes tagged with a tree id.
//
// Ports:
//   i_clk, i_arst_n        clock, asynchronous active-low reset
//   i_push, i_push_tree_id upstream push request and its target tree
//   o_push_ready           combinational push acceptance
//   o_push                 accepted push forwarded to the PIFO
//   i_task_fifo_full       PIFO task FIFO full
//   i_sched_en             scheduler enable
//   i_weight_wr/_tree_id/_data  per-tree weight write (0 disables a tree)
//   o_pop, o_pop_tree_id   pop strobe and tree id, decoded from state
//   o_tree_nonempty        per-tree occupancy != 0
// ---------------------------------------------------------------------------
module vpifo_pop_scheduler #(
  parameter int TREE_NUM      = 5,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int CNT_W         = 12,
  parameter int TREE_CAP      = 1024,
  parameter int WEIGHT_W      = 4,
  parameter int POP_GAP       = 2
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_push,
  input  logic [TREE_NUM_BITS-1:0] i_push_tree_id,
  output logic                     o_push_ready,
  output logic                     o_push,
  input  logic                     i_task_fifo_full,
  input  logic                     i_sched_en,
  input  logic                     i_weight_wr,
  input  logic [TREE_NUM_BITS-1:0] i_weight_tree_id,
  input  logic [WEIGHT_W-1:0]      i_weight_data,
  output logic                     o_pop,
  output logic [TREE_NUM_BITS-1:0] o_pop_tree_id,
  output logic [TREE_NUM-1:0]      o_tree_nonempty
);

  localparam int GAP_W = (POP_GAP > 2) ? $clog2(POP_GAP - 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((POP_GAP > 1) ? (POP_GAP - 2) : 0);
  localparam logic [TREE_NUM_BITS-1:0] TREE_LAST = TREE_NUM_BITS'(TREE_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t                     state_r, state_nxt_s;
  logic [TREE_NUM_BITS-1:0]   ptr_r, ptr_nxt_s;
  logic [TREE_NUM_BITS-1:0]   cur_r, cur_nxt_s;
  logic [WEIGHT_W-1:0]        credit_r, credit_nxt_s;
  logic [GAP_W-1:0]           gap_cnt_r, gap_cnt_nxt_s;
  logic [CNT_W-1:0]           occ_r     [TREE_NUM];
  logic [CNT_W-1:0]           occ_nxt_s [TREE_NUM];
  logic [WEIGHT_W-1:0]        weight_r  [TREE_NUM];
  logic [TREE_NUM-1:0]        nonempty_r;
  logic                       push_ready_s;
  logic                       push_acc_s;
  logic                       pop_s;
  logic                       scan_found_s;
  logic [TREE_NUM_BITS-1:0]   scan_tree_s;

  // Round-robin successor of a tree id.
  function automatic logic [TREE_NUM_BITS-1:0] next_tree(input logic [TREE_NUM_BITS-1:0] t);
    if (t == TREE_LAST) begin
      next_tree = {TREE_NUM_BITS{1'b0}};
    end else begin
      next_tree = t + TREE_NUM_BITS'(1);
    end
  endfunction

  assign pop_s = (state_r == ST_SERVE);

  // Push acceptance: fifo not full, valid tree id, tree below capacity.
  always_comb begin
    push_ready_s = 1'b0;
    if (!i_task_fifo_full && (int'(i_push_tree_id) < TREE_NUM)) begin
      push_ready_s = (occ_r[i_push_tree_id] < CNT_W'(TREE_CAP));
    end else begin
      push_ready_s = 1'b0;
    end
    push_acc_s = i_push & push_ready_s;
  end

  // Occupancy next value; a push and a pop on the same tree cancel out.
  always_comb begin
    for (int t = 0; t < TREE_NUM; t++) begin
      case ({push_acc_s && (i_push_tree_id == TREE_NUM_BITS'(t)),
             pop_s && (cur_r == TREE_NUM_BITS'(t))})
        2'b10:   occ_nxt_s[t] = occ_r[t] + CNT_W'(1);
        2'b01:   occ_nxt_s[t] = occ_r[t] - CNT_W'(1);
        default: occ_nxt_s[t] = occ_r[t];
      endcase
    end
  end

  // Scan from ptr for the first tree that is nonempty and has nonzero weight.
  always_comb begin
    logic [TREE_NUM_BITS-1:0] idx_s;
    scan_found_s = 1'b0;
    scan_tree_s  = ptr_r;
    idx_s        = ptr_r;
    for (int k = 0; k < TREE_NUM; k++) begin
      if (!scan_found_s && (occ_r[idx_s] != '0) && (weight_r[idx_s] != '0)) begin
        scan_found_s = 1'b1;
        scan_tree_s  = idx_s;
      end else begin
        scan_tree_s  = scan_tree_s;
      end
      idx_s = next_tree(idx_s);
    end
  end

  // Next-state logic: IDLE scan, one-cycle SERVE, GAP countdown, continue rule.
  always_comb begin
    state_nxt_s   = state_r;
    ptr_nxt_s     = ptr_r;
    cur_nxt_s     = cur_r;
    credit_nxt_s  = credit_r;
    gap_cnt_nxt_s = gap_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (i_sched_en && scan_found_s) begin
          cur_nxt_s    = scan_tree_s;
          credit_nxt_s = weight_r[scan_tree_s];
          state_nxt_s  = ST_SERVE;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_SERVE: begin
        credit_nxt_s = credit_r - WEIGHT_W'(1);
        if (POP_GAP > 1) begin
          gap_cnt_nxt_s = {GAP_W{1'b0}};
          state_nxt_s   = ST_GAP;
        end else if ((credit_r != WEIGHT_W'(1)) && (occ_nxt_s[cur_r] != '0) && i_sched_en) begin
          state_nxt_s   = ST_SERVE;
        end else begin
          ptr_nxt_s     = next_tree(cur_r);
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r != GAP_LAST) begin
          gap_cnt_nxt_s = gap_cnt_r + GAP_W'(1);
        end else if ((credit_r != '0) && (occ_r[cur_r] != '0) && i_sched_en) begin
          state_nxt_s   = ST_SERVE;
        end else begin
          ptr_nxt_s     = next_tree(cur_r);
          state_nxt_s   = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and scheduling registers.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_r   <= ST_IDLE;
      ptr_r     <= {TREE_NUM_BITS{1'b0}};
      cur_r     <= {TREE_NUM_BITS{1'b0}};
      credit_r  <= {WEIGHT_W{1'b0}};
      gap_cnt_r <= {GAP_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      ptr_r     <= ptr_nxt_s;
      cur_r     <= cur_nxt_s;
      credit_r  <= credit_nxt_s;
      gap_cnt_r <= gap_cnt_nxt_s;
    end
  end

  // Occupancy counters, nonempty flags and weight table.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int t = 0; t < TREE_NUM; t++) begin
        occ_r[t]    <= {CNT_W{1'b0}};
        weight_r[t] <= WEIGHT_W'(1);
      end
      nonempty_r <= {TREE_NUM{1'b0}};
    end else begin
      for (int t = 0; t < TREE_NUM; t++) begin
        occ_r[t]      <= occ_nxt_s[t];
        nonempty_r[t] <= (occ_nxt_s[t] != '0);
      end
      if (i_weight_wr && (int'(i_weight_tree_id) < TREE_NUM)) begin
        weight_r[i_weight_tree_id] <= i_weight_data;
      end
    end
  end

  // Output decode from registered state.
  always_comb begin
    o_pop           = pop_s;
    o_pop_tree_id   = cur_r;
    o_tree_nonempty = nonempty_r;
    o_push_ready    = push_ready_s;
    o_push          = push_acc_s;
  end

endmodule

// File: tb/tb_vpifo_pop_scheduler.sv
// Self-checking bench for vpifo_pop_scheduler: event-timed reference model,
// per-cycle compare process, directed scenarios with literal expectations,
// then randomized traffic.
module tb_vpifo_pop_scheduler;
  localparam int TN  = 5;
  localparam int CAP = 1024;
  localparam int PG  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push, full, en, wr;
  logic [2:0] push_id, wid;
  logic [3:0] wdata;
  logic       push_ready, push_fwd, pop;
  logic [2:0] pop_id;
  logic [4:0] nonempty;

  int checks = 0;
  int errors = 0;
  int cnt    = 0;

  // reference model: occupancy/weights as plain ints, pop timing as events
  int m_occ[TN];
  int m_wgt[TN];
  int m_ptr, m_cur, m_credit, m_decide;
  bit m_pop, m_idle;
  int dut_ids[$], dut_cyc[$], mdl_ids[$], mdl_cyc[$];

  vpifo_pop_scheduler dut (
    .i_clk(clk), .i_arst_n(rst_n),
    .i_push(push), .i_push_tree_id(push_id),
    .o_push_ready(push_ready), .o_push(push_fwd),
    .i_task_fifo_full(full), .i_sched_en(en),
    .i_weight_wr(wr), .i_weight_tree_id(wid), .i_weight_data(wdata),
    .o_pop(pop), .o_pop_tree_id(pop_id), .o_tree_nonempty(nonempty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cnt);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < TN; t++) begin
      m_occ[t] = 0;
      m_wgt[t] = 1;
    end
    m_ptr = 0; m_cur = 0; m_credit = 0; m_decide = -1;
    m_pop = 1'b0; m_idle = 1'b1;
  endtask

  function automatic bit model_ready(input int id);
    if (full || id >= TN) return 1'b0;
    return m_occ[id] < CAP;
  endfunction

  // Advance the model over the cycle numbered cnt, using that cycle's inputs.
  task automatic model_step();
    bit acc, nxt;
    int pid;
    pid = push_id;
    acc = push && model_ready(pid);
    nxt = 1'b0;
    if (m_pop) begin
      mdl_ids.push_back(m_cur);
      mdl_cyc.push_back(cnt);
      m_credit--;
      m_decide = cnt + PG - 1;
    end else if (m_decide == cnt) begin
      m_decide = -1;
      if (m_credit != 0 && m_occ[m_cur] != 0 && en) nxt = 1'b1;
      else begin
        m_ptr  = (m_cur + 1) % TN;
        m_idle = 1'b1;
      end
    end else if (m_idle && en) begin
      for (int k = 0; k < TN; k++) begin
        int t;
        t = (m_ptr + k) % TN;
        if (!nxt && m_occ[t] != 0 && m_wgt[t] != 0) begin
          nxt = 1'b1; m_cur = t; m_credit = m_wgt[t]; m_idle = 1'b0;
        end
      end
    end
    if (acc) m_occ[pid]++;
    if (m_pop) m_occ[m_cur]--;
    if (wr && int'(wid) < TN) m_wgt[wid] = wdata;
    m_pop = nxt;
  endtask

  initial forever begin
    @(posedge clk);
    if (rst_n) model_step();
    cnt++;
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    logic [4:0] ev;
    bit er;
    @(negedge clk);
    for (int t = 0; t < TN; t++) ev[t] = (m_occ[t] != 0);
    er = model_ready(int'(push_id));
    check("pop", {31'd0, pop}, {31'd0, m_pop});
    if (m_pop) check("pop_id", {29'd0, pop_id}, m_cur);
    check("nonempty", {27'd0, nonempty}, {27'd0, ev});
    check("push_ready", {31'd0, push_ready}, {31'd0, er});
    check("push_fwd", {31'd0, push_fwd}, {31'd0, push & er});
    if (pop === 1'b1) begin
      dut_ids.push_back(pop_id);
      dut_cyc.push_back(cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input int id);
    push = 1'b1; push_id = id[2:0];
    tick();
    push = 1'b0;
  endtask

  task automatic wr_weight(input int id, input int d);
    wr = 1'b1; wid = id[2:0]; wdata = d[3:0];
    tick();
    wr = 1'b0;
  endtask

  task automatic clear_logs();
    dut_ids.delete(); dut_cyc.delete(); mdl_ids.delete(); mdl_cyc.delete();
  endtask

  function automatic int count_id(input int id);
    int n = 0;
    foreach (dut_ids[i]) if (dut_ids[i] == id) n++;
    return n;
  endfunction

  initial begin
    int c;
    int exp_ids[8];
    int exp_gap[7];
    exp_ids = '{0, 0, 1, 0, 0, 1, 1, 1};
    exp_gap = '{2, 3, 3, 2, 3, 3, 3};
    rst_n = 1'b0; push = 1'b0; full = 1'b0; en = 1'b0; wr = 1'b0;
    push_id = 3'd0; wid = 3'd0; wdata = 4'd0;
    model_reset();

    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      push = 1'($urandom); push_id = 3'($urandom); full = 1'($urandom);
      en = 1'($urandom); wr = 1'($urandom); wid = 3'($urandom); wdata = 4'($urandom);
      tick();
      check("rst_pop", {31'd0, pop}, 32'd0);
      check("rst_pop_id", {29'd0, pop_id}, 32'd0);
      check("rst_nonempty", {27'd0, nonempty}, 32'd0);
    end
    push = 1'b0; wr = 1'b0; en = 1'b0; full = 1'b0; push_id = 3'd0;
    #1 check("rst_ready_t0", {31'd0, push_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // single push to tree 2 on an idle, enabled scheduler
    en = 1'b1;
    tick();
    clear_logs();
    c = cnt;
    do_push(2);
    repeat (8) tick();
    check("single_pops", dut_ids.size(), 32'd1);
    if (dut_ids.size() > 0) begin
      check("single_id", dut_ids[0], 32'd2);
      check("single_cycle", dut_cyc[0], c + 2);
    end
    check("single_model_cycle", (mdl_cyc.size() > 0) ? mdl_cyc[0] : -1, c + 2);
    check("single_empty", {27'd0, nonempty}, 32'd0);

    // weighted round robin: tree0 weight 2, tree1 weight 1
    en = 1'b0;
    wr_weight(0, 2);
    for (int i = 0; i < 4; i++) do_push(0);
    for (int i = 0; i < 4; i++) do_push(1);
    clear_logs();
    en = 1'b1;
    repeat (40) tick();
    check("wrr_count", dut_ids.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < dut_ids.size()) check("wrr_id", dut_ids[i], exp_ids[i]);
      if (i < mdl_ids.size()) check("wrr_model_id", mdl_ids[i], exp_ids[i]);
    end
    for (int i = 0; i < 7; i++)
      if (i + 1 < dut_cyc.size()) check("wrr_spacing", dut_cyc[i+1] - dut_cyc[i], exp_gap[i]);

    // weight 0 disables tree 1 until rewritten
    en = 1'b0;
    wr_weight(1, 0);
    for (int i = 0; i < 3; i++) do_push(0);
    for (int i = 0; i < 3; i++) do_push(1);
    clear_logs();
    en = 1'b1;
    repeat (30) tick();
    check("w0_tree0_pops", count_id(0), 32'd3);
    check("w0_tree1_pops", count_id(1), 32'd0);
    check("w0_tree1_held", {31'd0, nonempty[1]}, 32'd1);
    clear_logs();
    wr_weight(1, 1);
    repeat (30) tick();
    check("w1_tree1_pops", count_id(1), 32'd3);
    check("w1_empty", {27'd0, nonempty}, 32'd0);

    // push into tree 0 during its own SERVE cycle
    en = 1'b0;
    do_push(0); do_push(0);
    clear_logs();
    en = 1'b1;
    tick();
    check("serve_cycle_pop", {31'd0, pop}, 32'd1);
    push = 1'b1; push_id = 3'd0;
    tick();
    push = 1'b0;
    repeat (20) tick();
    check("same_cycle_pops", count_id(0), 32'd3);

    // drop enable during GAP
    en = 1'b0;
    for (int i = 0; i < 3; i++) do_push(0);
    clear_logs();
    en = 1'b1;
    tick();
    tick();
    en = 1'b0;
    repeat (12) tick();
    check("disable_pops", dut_ids.size(), 32'd1);
    check("disable_held", {31'd0, nonempty[0]}, 32'd1);

    // capacity on tree 3, then fifo full
    push = 1'b1; push_id = 3'd3;
    repeat (CAP) tick();
    #1 check("cap_ready_t3", {31'd0, push_ready}, 32'd0);
    push_id = 3'd4;
    #1 check("cap_ready_t4", {31'd0, push_ready}, 32'd1);
    full = 1'b1;
    for (int t = 0; t < TN; t++) begin
      push_id = t[2:0];
      #1 check("full_ready", {31'd0, push_ready}, 32'd0);
      check("full_push", {31'd0, push_fwd}, 32'd0);
    end
    push = 1'b0; full = 1'b0;

    // reset asserted during GAP
    en = 1'b1;
    tick();
    check("pre_rst_serve", {31'd0, pop}, 32'd1);
    tick();
    check("pre_rst_gap", {31'd0, pop}, 32'd0);
    rst_n = 1'b0;
    model_reset();
    push_id = 3'd3;
    #1 check("arst_pop", {31'd0, pop}, 32'd0);
    check("arst_nonempty", {27'd0, nonempty}, 32'd0);
    check("arst_ready_t3", {31'd0, push_ready}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      push = 1'($urandom_range(0, 1)); push_id = 3'($urandom_range(0, 7));
      full = ($urandom_range(0, 9) == 0); en = ($urandom_range(0, 9) != 0);
      wr = ($urandom_range(0, 29) == 0); wid = 3'($urandom_range(0, 7));
      wdata = 4'($urandom_range(0, 15));
      if (i == 1500) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    push = 1'b0; wr = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
